// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// datapath select codes and the retirement predicate.
package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsource_t;

  // An instruction retires on the step back to FETCH from a final state;
  // MEMWR only finishes once memory has accepted the write.
  function automatic logic retires(input logic [3:0] s, input logic mem_ready);
    return (s == S_MEMWB) || (s == S_RWB) || (s == S_BRANCH) ||
           (s == S_JUMP) || (s == S_ADDIWB) || ((s == S_MEMWR) && mem_ready);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decode for the multicycle MIPS controller.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       is_zero,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource
);

  always_comb begin
    pc_en    = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    ALUOp    = ALUOP_ADD;
    PCSource = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        pc_en   = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH2;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        pc_en    = is_zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        pc_en    = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
    // Reset abandons any in-flight access, so no side-effecting strobe may leak out.
    if (reset) begin
      pc_en    = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: next-state logic, illegal-opcode pulse and
// retired-instruction counter; control decode lives in mips_ctrl_decode.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             globalclock,
  input  logic             globalreset,
  input  logic [5:0]       opcode,
  input  logic             isZero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0] next_state;
  logic       illegal_next;

  always_comb begin
    next_state   = state;
    illegal_next = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default: begin
            next_state   = S_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      // The IR still holds the opcode, so lw/sw split here rather than in DECODE.
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_EXEC:   next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: next_state = S_FETCH;
      default: begin
        next_state   = S_FETCH;
        illegal_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge globalclock) begin
    if (globalreset) begin
      state       <= S_FETCH;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      state      <= next_state;
      illegal_op <= illegal_next;
      if (retires(state, mem_ready)) instr_count <= instr_count + CNT_ONE;
    end
  end

  mips_ctrl_decode u_decode (
    .state     (state),
    .reset     (globalreset),
    .mem_ready (mem_ready),
    .is_zero   (isZero),
    .pc_en     (pc_en),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSource  (PCSource)
  );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed per-cycle vectors push expected
// state/controls/counter; a negedge monitor pops and compares.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 32;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BAD  = 6'b111111;
  localparam logic [CNT_W-1:0] ONES = '1;

  logic globalclock;
  logic globalreset;
  logic [5:0] opcode;
  logic isZero;
  logic mem_ready;
  logic pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic illegal_op;
  logic [CNT_W-1:0] instr_count;

  typedef struct {
    string            tag;
    logic [3:0]       st;
    logic [14:0]      ctl;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_test = "reset";

  mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .globalclock (globalclock),
    .globalreset (globalreset),
    .opcode      (opcode),
    .isZero      (isZero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial globalclock = 1'b0;
  always #5 globalclock = ~globalclock;

  // Reference control word per state, packed as
  // {pc_en,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}.
  function automatic logic [14:0] exp_ctl(input logic [3:0] st, input logic mr,
                                          input logic z, input logic rst);
    logic pe, iod, mrd, mwr, irw, rdst, m2r, rw, sa;
    logic [1:0] sb2, op, pcs;
    {pe, iod, mrd, mwr, irw, rdst, m2r, rw, sa} = '0;
    sb2 = 2'b00; op = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb2 = 2'b01; pe = mr; irw = mr; end
      4'd1:  sb2 = 2'b11;
      4'd2:  begin sa = 1; sb2 = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rdst = 1; rw = 1; end
      4'd8:  begin sa = 1; op = 2'b01; pcs = 2'b01; pe = z; end
      4'd9:  begin pcs = 2'b10; pe = 1; end
      4'd10: begin sa = 1; sb2 = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (rst) begin pe = 0; irw = 0; rw = 0; mrd = 0; mwr = 0; end
    return {pe, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb2, op, pcs};
  endfunction

  // Drive one cycle of inputs, record what the DUT must show during it, then
  // advance to just past the next rising edge.
  task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic z,
                               input logic rst, input logic [3:0] st, input logic ill,
                               input logic [CNT_W-1:0] cnt);
    exp_t e;
    opcode = op; mem_ready = mr; isZero = z; globalreset = rst;
    e.tag = cur_test; e.st = st; e.ctl = exp_ctl(st, mr, z, rst); e.ill = ill; e.cnt = cnt;
    sb.push_back(e);
    @(posedge globalclock);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [14:0] got;
    got = {pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, PCSource};
    n_checks++;
    if (state !== e.st) begin
      n_errors++;
      $display("[TB] FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
    end
    n_checks++;
    if (got !== e.ctl) begin
      n_errors++;
      $display("[TB] FAIL %s controls (state %0d): got %b expected %b", e.tag, e.st, got, e.ctl);
    end
    n_checks++;
    if (illegal_op !== e.ill) begin
      n_errors++;
      $display("[TB] FAIL %s illegal_op: got %b expected %b", e.tag, illegal_op, e.ill);
    end
    n_checks++;
    if (instr_count !== e.cnt) begin
      n_errors++;
      $display("[TB] FAIL %s instr_count: got %0d expected %0d", e.tag, instr_count, e.cnt);
    end
  endtask

  // Monitor: compare mid-cycle, away from the clock edge.
  always @(negedge globalclock) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    #100000;
    n_errors++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    globalreset = 1'b1; opcode = RTY; isZero = 1'b0; mem_ready = 1'b1;
    @(posedge globalclock);
    #1;

    cur_test = "reset";
    applyStimulus(RTY, 1, 0, 1, 4'd0, 0, 0);

    cur_test = "rtype";
    applyStimulus(RTY, 1, 0, 0, 4'd0, 0, 0);
    applyStimulus(RTY, 1, 0, 0, 4'd1, 0, 0);
    applyStimulus(RTY, 1, 0, 0, 4'd6, 0, 0);
    applyStimulus(RTY, 1, 0, 0, 4'd7, 0, 0);

    cur_test = "lw_stall";
    applyStimulus(LW, 1, 0, 0, 4'd0, 0, 1);
    applyStimulus(LW, 0, 0, 0, 4'd1, 0, 1);
    applyStimulus(LW, 1, 0, 0, 4'd2, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(LW, 0, 0, 0, 4'd3, 0, 1);
    applyStimulus(LW, 1, 0, 0, 4'd3, 0, 1);
    applyStimulus(LW, 0, 0, 0, 4'd4, 0, 1);

    cur_test = "sw_stall";
    applyStimulus(SW, 1, 0, 0, 4'd0, 0, 2);
    applyStimulus(SW, 1, 0, 0, 4'd1, 0, 2);
    applyStimulus(SW, 0, 0, 0, 4'd2, 0, 2);
    applyStimulus(SW, 0, 0, 0, 4'd5, 0, 2);
    applyStimulus(SW, 0, 0, 0, 4'd5, 0, 2);
    applyStimulus(SW, 1, 0, 0, 4'd5, 0, 2);

    cur_test = "beq_taken";
    applyStimulus(BEQ, 1, 1, 0, 4'd0, 0, 3);
    applyStimulus(BEQ, 1, 1, 0, 4'd1, 0, 3);
    applyStimulus(BEQ, 1, 1, 0, 4'd8, 0, 3);

    cur_test = "beq_not_taken";
    applyStimulus(BEQ, 1, 0, 0, 4'd0, 0, 4);
    applyStimulus(BEQ, 1, 0, 0, 4'd1, 0, 4);
    applyStimulus(BEQ, 1, 0, 0, 4'd8, 0, 4);

    cur_test = "addi";
    applyStimulus(ADDI, 1, 0, 0, 4'd0, 0, 5);
    applyStimulus(ADDI, 1, 0, 0, 4'd1, 0, 5);
    applyStimulus(ADDI, 1, 0, 0, 4'd10, 0, 5);
    applyStimulus(ADDI, 1, 0, 0, 4'd11, 0, 5);

    cur_test = "illegal";
    applyStimulus(BAD, 1, 0, 0, 4'd0, 0, 6);
    applyStimulus(BAD, 1, 0, 0, 4'd1, 0, 6);
    applyStimulus(BAD, 0, 0, 0, 4'd0, 1, 6);
    applyStimulus(BAD, 0, 0, 0, 4'd0, 0, 6);

    cur_test = "reset_in_memwr";
    applyStimulus(SW, 1, 0, 0, 4'd0, 0, 6);
    applyStimulus(SW, 1, 0, 0, 4'd1, 0, 6);
    applyStimulus(SW, 0, 0, 0, 4'd2, 0, 6);
    applyStimulus(SW, 0, 0, 0, 4'd5, 0, 6);
    applyStimulus(SW, 0, 0, 1, 4'd5, 0, 6);
    applyStimulus(SW, 0, 0, 0, 4'd0, 0, 0);

    cur_test = "jump_wrap";
    force dut.instr_count = ONES;
    applyStimulus(JMP, 0, 0, 0, 4'd0, 0, ONES);
    applyStimulus(JMP, 1, 0, 0, 4'd0, 0, ONES);
    applyStimulus(JMP, 1, 0, 0, 4'd1, 0, ONES);
    release dut.instr_count;
    applyStimulus(JMP, 1, 0, 0, 4'd9, 0, ONES);
    applyStimulus(JMP, 0, 0, 0, 4'd0, 0, 0);

    @(posedge globalclock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL use one clock; reset is synchronous and active-high: globalclock  in  1  (rising edge only); globalreset  in  1  (synchronous, active-high).
REQ-003 SHALL have opcode  in  6  instruction bits [31:26] held in the datapath IR.
REQ-004 SHALL have isZero  in  1  ALU zero flag from the datapath.
REQ-005 SHALL have mem_ready  in  1  unified memory has completed the current read or write this cycle.
REQ-006 SHALL have pc_en  out  1  PC register load enable.
REQ-007 SHALL have IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 SHALL have MemRead / MemWrite  out  1 each  memory request strobes; they are never both high.
REQ-009 SHALL have IRWrite  out  1  instruction register load.
REQ-010 SHALL have RegDst / MemtoReg / RegWrite  out  1 each  register-file write controls.
REQ-011 SHALL have ALUSrcA  out  1 (0 = PC, 1 = A) and ALUSrcB  out  2 (00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2).
REQ-012 SHALL have ALUOp  out  2 (00 = add, 01 = sub, 10 = funct-decoded) and PCSource  out  2 (00 = ALU result, 01 = ALUOut, 10 = jump target).
REQ-013 SHALL have state  out  4 (debug: current FSM state), illegal_op  out  1 (one-cycle pulse), and instr_count  out  CNT_W (retired-instruction count).

Function
REQ-014 SHALL be a Moore FSM: all outputs decode from the state register, except pc_en, IRWrite, MemWrite and MemRead, which may also use mem_ready/isZero as stated below; unlisted controls are 0.
REQ-015 FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; pc_en=IRWrite=mem_ready; FSM stays in FETCH until mem_ready, then goes to DECODE.
REQ-016 DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; any other -> FETCH with illegal_op=1 on the following cycle.
REQ-017 MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD(3): MemRead=1, IorD=1; FSM holds until mem_ready, then goes to MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
REQ-019 MEMWR(5): MemWrite=1, IorD=1; FSM holds until mem_ready, then goes to FETCH.
REQ-020 EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RWB(7): RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
REQ-021 BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, pc_en=isZero, then FETCH.
REQ-022 JUMP(9): PCSource=10, pc_en=1, then FETCH.
REQ-023 ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDIWB(11): RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
REQ-024 Encodings 12-15 are unreachable; if entered, the FSM goes to FETCH next cycle and pulses illegal_op.
REQ-025 Cycle counts with mem_ready always high: R-type/addi 4, lw 5, sw 4, beq 3, j 3.
REQ-026 instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB; it does not increment on an illegal-opcode return; it wraps all-ones -> 0.
REQ-027 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored; mem_ready held low stalls indefinitely with request strobes held steady.

Reset
REQ-028 While globalreset=1 at a rising edge: state<=FETCH, instr_count<=0, illegal_op<=0.
REQ-029 While globalreset=1: pc_en, IRWrite, RegWrite, MemRead and MemWrite SHALL be forced to 0 combinationally.
REQ-030 Reset mid-operation (including during a stalled MEMRD/MEMWR) abandons the access; no register write or PC update results.

Structure
REQ-031 Package mips_ctrl_pkg SHALL hold the state encodings, opcode constants, and the ALUSrcB/ALUOp/PCSource encodings.
REQ-032 The state->control decode SHALL be a combinational sub-module mips_ctrl_decode; next-state logic, illegal_op and instr_count stay in mips_mc_ctrl.

Verification
REQ-033 Reset then opcode=000000 with mem_ready=1: states 0,1,6,7,0; RegDst=1 and RegWrite=1 in state 7; instr_count=1.
REQ-034 lw with mem_ready low for 3 cycles in MEMRD: MEMRD held 4 cycles with MemRead=1, IorD=1; MEMWB then asserts MemtoReg=1; total 8 cycles.
REQ-035 beq with isZero=1 gives pc_en=1, PCSource=01 in BRANCH; with isZero=0, pc_en=0; both cases increment instr_count.
REQ-036 opcode=111111 gives DECODE -> FETCH, illegal_op high exactly one cycle, and instr_count unchanged.
REQ-037 globalreset asserted in a stalled MEMWR: MemWrite=0 immediately, state=0 after the edge, instr_count=0.
REQ-038 Preload instr_count to all-ones (force), then run j: instr_count wraps to 0, with pc_en=1 and PCSource=10 in JUMP.
